suma_mult_engine: RTL and testbench
===================================

# suma_mult_engine

Parametrised sequential arithmetic engine; the next generation of the team's fixed 16-bit sum/multiply block. It accepts a start request with latched operands. It computes one of three selectable functions over multiple cycles: triangular sum, shift-add product, or multiply-accumulate. It presents the result with busy/done status. It sits behind the user project wrapper, and its operands and result are mapped onto Wishbone data bits or logic-analyzer lines.

## Interface
- WIDTH, 16, operand width in bits (≥2); result width is 2*WIDTH.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- mode  in  2  function select: 00 SUM, 01 MULT, 10 MAC, 11 reserved.
- op_a  in  WIDTH  first operand (n for SUM).
- op_b  in  WIDTH  second operand (ignored by SUM).
- x  out  2*WIDTH  result register.
- busy  out  1  high while iterating.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE. Reset: state IDLE, x=0, busy=0, done=0, internal accumulator/counters 0.
- IDLE: on start=1, latch mode/op_a/op_b; operand changes after acceptance are ignored.
- Iteration count L: SUM → op_a; MULT/MAC → WIDTH; reserved mode or SUM with op_a=0 → 0.
- L>0: go to RUN. L=0: go directly to DONE.
- SUM: accumulator starts at 0, counter k starts at 1; each RUN cycle adds k, then k++. Result = op_a*(op_a+1)/2, which always fits in 2*WIDTH bits, so no overflow.
- MULT: classic shift-add; each RUN cycle examines one multiplier bit, LSB first, and adds the shifted multiplicand if the bit is set. Result = op_a*op_b, exact.
- MAC: same as MULT, but accumulator initial value = current x. Result = (x + op_a*op_b) mod 2^(2*WIDTH); wrap is silent.
- Reserved mode: x unchanged, done still pulses.
- At the last RUN edge (or the accept edge when L=0): x ← accumulator (SUM/MULT/MAC), state → DONE.
- DONE: done=1 for one cycle, then → IDLE unconditionally. A start seen during RUN or DONE is ignored, not queued.
- x holds its value from one completion to the next; it changes only at completion or reset.

## Timing
- The accepting edge is edge 0. Iteration i occurs at edge i (1..L).
- busy=1 in the L cycles between edge 0 and edge L; busy=0 in IDLE and DONE.
- done=1 only in the cycle between edge L and edge L+1. x is valid with new value in that same cycle.
- Earliest next accept: edge L+2 (start must be high during the IDLE cycle).
- SUM latency varies with the operand (up to 2^WIDTH−1 iterations). MULT/MAC latency is fixed at WIDTH.
- rst=1 at any edge, including mid-RUN or DONE: the operation aborts and all outputs return to reset values on that edge. No done pulse is emitted for the aborted operation. rst dominates start on the same edge.

## Structure
- Shared package suma_mult_pkg: mode encodings (MODE_SUM, MODE_MULT, MODE_MAC, MODE_RSVD), state enum (IDLE/RUN/DONE), and the default WIDTH constant.
- Single module. The iteration counter is sized $clog2 of the maximum L, which covers both WIDTH and 2^WIDTH−1.
- Optional sub-module: suma_mult_shiftadd (one shift-add step: accumulator, multiplicand, multiplier bit → next values), reused by MULT and MAC.

## Test plan
- WIDTH=16, SUM op_a=10, start one cycle → busy 10 cycles, done at edge 10→11 window, x=55 (0x37).
- MULT op_a=0xFFFF op_b=0xFFFF → done after 16 iterations, x=0xFFFE0001. Then MULT 0×0x1234 → x=0.
- MAC sequence after reset: 3*4 then 5*6 → x=12 then x=42. Preload x=0xFFFFFFFF via MAC, then MAC 1*1 → x=0 (wrap).
- SUM op_a=0 and mode=11 → no busy, done in the cycle after the accept edge; x=0 for SUM, x unchanged for reserved.
- start held high through a MULT run with changing op_a/op_b → exactly one done per accepted request; result uses the latched operands; the next accept occurs only after DONE→IDLE.
- rst asserted at iteration 5 of SUM op_a=100 → next cycle state IDLE, x=0, busy=0, no done pulse. A following SUM op_a=3 gives x=6.

Source files
------------

// File: rtl/suma_mult_pkg.sv
// suma_mult_pkg
//   Shared definitions for the suma_mult engine: function-select encodings,
//   controller state encoding and the default operand width.
package suma_mult_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    MODE_SUM  = 2'b00,
    MODE_MULT = 2'b01,
    MODE_MAC  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/suma_mult_engine_if.sv
// suma_mult_engine_if
//   Request/result bundle of the suma_mult engine.
//   start  : request, honoured only while the engine is idle
//   mode   : function select (SUM / MULT / MAC / reserved)
//   op_a   : first operand (n for SUM)
//   op_b   : second operand (unused by SUM)
//   x      : result register, 2*WIDTH bits
//   busy   : high while iterating
//   done   : one-cycle completion pulse
//   master drives the request side, slave (the engine) drives the result side.
interface suma_mult_engine_if #(
  parameter int WIDTH = suma_mult_pkg::WIDTH_DEF
);
  logic                 start;
  logic [1:0]           mode;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [2*WIDTH-1:0]   x;
  logic                 busy;
  logic                 done;

  modport master (
    output start, mode, op_a, op_b,
    input  x, busy, done
  );

  modport slave (
    input  start, mode, op_a, op_b,
    output x, busy, done
  );

endinterface

// File: rtl/suma_mult_shiftadd.sv
// suma_mult_shiftadd
//   One step of a shift-add multiplier, shared by MULT and MAC.
//   acc_in / acc_out       : partial product before / after this step
//   mcand_in / mcand_out   : multiplicand, shifted left one place per step
//   mplier_in / mplier_out : multiplier, shifted right one place per step;
//                            bit 0 decides whether the multiplicand is added
module suma_mult_shiftadd #(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [2*WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] acc_out,
  output logic [2*WIDTH-1:0] mcand_out,
  output logic [WIDTH-1:0]   mplier_out
);

  // Sum wraps modulo 2^(2*WIDTH); MAC relies on that silent wrap.
  assign acc_out    = mplier_in[0] ? (acc_in + mcand_in) : acc_in;
  assign mcand_out  = mcand_in << 1;
  assign mplier_out = mplier_in >> 1;

endmodule

// File: rtl/suma_mult_engine.sv
// suma_mult_engine
//   Multi-cycle arithmetic engine computing one of:
//     SUM  : x = op_a*(op_a+1)/2        (op_a iterations)
//     MULT : x = op_a*op_b              (WIDTH iterations)
//     MAC  : x = x + op_a*op_b, wrapped (WIDTH iterations)
//   Ports:
//     clk  : clock, all state changes on the rising edge
//     rst  : synchronous active-high reset, aborts any operation in flight
//     bus  : suma_mult_engine_if slave (start/mode/op_a/op_b in,
//            x/busy/done out)
//   Operands and mode are latched on the accepting edge; x changes only on
//   completion or reset.
module suma_mult_engine
  import suma_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  suma_mult_engine_if.slave   bus
);

  localparam int ACC_W = 2 * WIDTH;
  // Largest iteration count is the SUM case with op_a = 2^WIDTH-1.
  localparam int MAX_L = (1 << WIDTH) - 1;
  localparam int CNT_W = $clog2(MAX_L + 1);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [ACC_W-1:0]   x_q, x_d;

  mode_e              start_mode;
  logic [CNT_W-1:0]   start_len;
  logic [ACC_W-1:0]   start_acc;
  logic [ACC_W-1:0]   step_acc;

  logic [ACC_W-1:0]   sa_acc;
  logic [ACC_W-1:0]   sa_mcand;
  logic [WIDTH-1:0]   sa_mplier;

  suma_mult_shiftadd #(
    .WIDTH (WIDTH)
  ) u_shiftadd (
    .acc_in     (acc_q),
    .mcand_in   (mcand_q),
    .mplier_in  (mplier_q),
    .acc_out    (sa_acc),
    .mcand_out  (sa_mcand),
    .mplier_out (sa_mplier)
  );

  // Controller and datapath next-state logic.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    x_d        = x_q;

    // Iteration count and accumulator seed for a request seen this cycle.
    start_mode = mode_e'(bus.mode);
    start_len  = '0;
    start_acc  = '0;
    case (start_mode)
      MODE_SUM:  start_len = CNT_W'(bus.op_a);
      MODE_MULT: start_len = CNT_W'(WIDTH);
      MODE_MAC: begin
        start_len = CNT_W'(WIDTH);
        start_acc = x_q;
      end
      default:   start_len = '0;
    endcase

    // SUM adds the running index k (held in cnt_q); MULT/MAC take a
    // shift-add step.
    step_acc = (mode_q == MODE_SUM) ? (acc_q + ACC_W'(cnt_q)) : sa_acc;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d   = start_mode;
          len_d    = start_len;
          cnt_d    = CNT_W'(1);
          acc_d    = start_acc;
          mcand_d  = ACC_W'(bus.op_a);
          mplier_d = bus.op_b;
          if (start_len == '0) begin
            // Zero-length work completes on the accept edge; the reserved
            // mode leaves x untouched.
            state_d = DONE;
            if (start_mode != MODE_RSVD) begin
              x_d = start_acc;
            end
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        acc_d    = step_acc;
        mcand_d  = sa_mcand;
        mplier_d = sa_mplier;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == len_q) begin
          x_d     = step_acc;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= MODE_SUM;
      len_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      x_q      <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      x_q      <= x_d;
    end
  end

  assign bus.x    = x_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_suma_mult_engine.sv
// tb_suma_mult_engine
//   Self-checking bench for suma_mult_engine (WIDTH=16). A behavioural model
//   computes each expected result and iteration count from plain arithmetic.
module tb_suma_mult_engine;
  import suma_mult_pkg::*;

  localparam int W     = 16;
  localparam int LIMIT = 70000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  suma_mult_engine_if #(.WIDTH(W)) bus ();

  suma_mult_engine #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          total = 0;
  int          bad   = 0;
  logic [63:0] cur_x;
  logic [63:0] exp_x;
  int          exp_len;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Model: expected iteration count and result for one request.
  task automatic arm(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    case (m)
      2'b00: begin exp_len = int'(a); exp_x = (64'(a) * (64'(a) + 64'd1)) / 64'd2; end
      2'b01: begin exp_len = W;       exp_x = prod; end
      2'b10: begin exp_len = W;       exp_x = (cur_x + prod) & 64'hFFFF_FFFF; end
      default: begin exp_len = 0;     exp_x = cur_x; end
    endcase
    cur_x = exp_x;
  endtask

  task automatic start_op(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.op_a  = a;
    bus.op_b  = b;
    arm(m, a, b);
    @(posedge clk);
  endtask

  // Runs from just after the accepting edge to the done cycle (returns at
  // that cycle's negedge). Operands are scrambled while the engine works.
  task automatic finish_op(input bit hold, input string tag);
    int cyc;
    int busy_n;
    bit got;
    cyc = 0; busy_n = 0; got = 1'b0;
    while (!got && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (!hold) bus.start = 1'b0;
      if (bus.done) begin
        got = 1'b1;
      end else begin
        if (bus.busy) busy_n++;
        bus.op_a = 16'($urandom);
        bus.op_b = 16'($urandom);
      end
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_len));
    chk({tag, "_done_latency"}, 64'(cyc), 64'(exp_len + 1));
    chk({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
    chk({tag, "_x"}, 64'(bus.x), exp_x);
  endtask

  task automatic run_op(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                        input string tag);
    start_op(m, a, b);
    finish_op(1'b0, tag);
    @(negedge clk);
    chk({tag, "_done_pulse_end"}, 64'(bus.done), 64'd0);
    chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cur_x = '0;
    chk("reset_x", 64'(bus.x), 64'd0);
  endtask

  initial begin
    rst      = 1'b1;
    bus.start = 1'b0;
    bus.mode = 2'b00;
    bus.op_a = '0;
    bus.op_b = '0;
    cur_x    = '0;
    exp_x    = '0;
    exp_len  = 0;
    repeat (3) @(negedge clk);
    chk("reset_x", 64'(bus.x), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    rst = 1'b0;

    // Directed cases.
    run_op(2'b00, 16'd10, 16'd0, "sum10");
    chk("sum10_val", 64'(bus.x), 64'h37);
    run_op(2'b01, 16'hFFFF, 16'hFFFF, "mult_max");
    chk("mult_max_val", 64'(bus.x), 64'hFFFE_0001);
    run_op(2'b01, 16'h0000, 16'h1234, "mult_zero");
    chk("mult_zero_val", 64'(bus.x), 64'h0);

    do_reset();
    run_op(2'b10, 16'd3, 16'd4, "mac1");
    chk("mac1_val", 64'(bus.x), 64'd12);
    run_op(2'b10, 16'd5, 16'd6, "mac2");
    chk("mac2_val", 64'(bus.x), 64'd42);
    run_op(2'b01, 16'hFFFF, 16'hFFFF, "pre_mult");
    run_op(2'b10, 16'hFFFF, 16'd2, "pre_mac");
    chk("preload_val", 64'(bus.x), 64'hFFFF_FFFF);
    run_op(2'b10, 16'd1, 16'd1, "mac_wrap");
    chk("mac_wrap_val", 64'(bus.x), 64'h0);

    run_op(2'b01, 16'd7, 16'd9, "pre_rsvd");
    run_op(2'b11, 16'h5555, 16'hAAAA, "rsvd");
    chk("rsvd_keep", 64'(bus.x), 64'd63);
    run_op(2'b00, 16'd0, 16'hBEEF, "sum0");
    chk("sum0_val", 64'(bus.x), 64'h0);
    run_op(2'b00, 16'd1, 16'd0, "sum1");

    // start held high through a MULT run with changing operands.
    start_op(2'b01, 16'h1234, 16'h00FF);
    finish_op(1'b1, "hold1");
    bus.op_a = 16'd3;
    bus.op_b = 16'd7;
    arm(2'b01, 16'd3, 16'd7);
    @(negedge clk);
    chk("hold_idle_busy", 64'(bus.busy), 64'd0);
    chk("hold_idle_done", 64'(bus.done), 64'd0);
    @(posedge clk);
    finish_op(1'b0, "hold2");
    @(negedge clk);
    chk("hold2_done_pulse_end", 64'(bus.done), 64'd0);

    // Abort mid-run: rst at the edge of iteration 5.
    start_op(2'b00, 16'd100, 16'd0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_x", 64'(bus.x), 64'd0);
    rst = 1'b0;
    cur_x = '0;
    @(negedge clk);
    chk("abort_no_done", 64'(bus.done), 64'd0);
    run_op(2'b00, 16'd3, 16'd0, "sum3");
    chk("sum3_val", 64'(bus.x), 64'd6);

    // Randomised requests against the model.
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  m;
      logic [15:0] a;
      logic [15:0] b;
      m = 2'($urandom_range(0, 3));
      a = (m == 2'b00) ? 16'($urandom_range(0, 200)) : 16'($urandom);
      b = 16'($urandom);
      run_op(m, a, b, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
